round_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 38 +++
 rtl/tick_gen.sv | 28 ++
 rtl/round_sequencer.sv | 148 ++++++++++++++
 tb/tb_round_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: doll-phase state codes, winner codes and the start distance.
// Pure declarations plus one combinational helper; no clocked logic and no flow control.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_GREEN = 3'd2,
    ST_TURN  = 3'd3,
    ST_RED   = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [4:0] POS_START = 5'd26;

  // Time-out verdict: among live players the one closer to the line wins.
  function automatic logic [1:0] timeout_winner(input logic [4:0] p1, input logic [4:0] p2,
                                                input logic d1, input logic d2);
    logic [1:0] res;
    res = WIN_NONE;
    if (!d1 && !d2) begin
      if (p1 < p2)      res = WIN_P1;
      else if (p2 < p1) res = WIN_P2;
      else              res = WIN_TIE;
    end else if (!d1) begin
      res = WIN_P1;
    end else if (!d2) begin
      res = WIN_P2;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider: one-cycle tick every DIV cycles, restartable by a synchronous clear.
// tick is combinational from the count (asserted on the wrap cycle); no backpressure.
module tick_gen #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Round flow for "1-2-3 wooden man": countdown, green/turn/red doll phases, game clock, end/winner.
// All outputs registered (change one cycle after the deciding edge); start ignored while a round runs.
module round_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int SEC_TICKS  = 10,
  parameter int GREEN_MIN  = 15,
  parameter int TURN_TICKS = 5,
  parameter int RED_TICKS  = 30,
  parameter int GAME_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] p1_pos,
  input  logic [4:0] p2_pos,
  input  logic       p1_die,
  input  logic       p2_die,
  output logic       round_rst,
  output logic       en,
  output logic       allow,
  output logic [2:0] phase,
  output logic [1:0] countdown,
  output logic [7:0] time_left,
  output logic [1:0] winner
);

  localparam int PW = 8;

  state_t        state;
  state_t        nxt;
  logic [1:0]    nxt_win;
  logic          tick;
  logic          tick_clr;
  logic          running;
  logic          sec_last;
  logic          p1_zero;
  logic          p2_zero;
  logic [PW-1:0] ph_cnt;
  logic [PW-1:0] green_len;
  logic [7:0]    sec_sub;
  logic [7:0]    lfsr;

  assign phase    = state;
  assign running  = (state == ST_GREEN) || (state == ST_TURN) || (state == ST_RED);
  assign sec_last = tick && (sec_sub == 8'(SEC_TICKS - 1));
  assign p1_zero  = (p1_pos == 5'd0);
  assign p2_zero  = (p2_pos == 5'd0);
  // Every state entry restarts the divider so each phase is a whole number of ticks.
  assign tick_clr = (nxt != state);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    nxt     = state;
    nxt_win = winner;
    case (state)
      ST_IDLE:  if (start) nxt = ST_READY;
      ST_READY: if (sec_last && countdown == 2'd1) nxt = ST_GREEN;
      ST_GREEN: if (tick && ph_cnt == green_len - PW'(1)) nxt = ST_TURN;
      ST_TURN:  if (tick && ph_cnt == PW'(TURN_TICKS - 1)) nxt = ST_RED;
      ST_RED:   if (tick && ph_cnt == PW'(RED_TICKS - 1)) nxt = ST_GREEN;
      ST_OVER: begin
        if (start) begin
          nxt     = ST_READY;
          nxt_win = WIN_NONE;
        end
      end
      default:  nxt = ST_IDLE;
    endcase
    // End checks override any phase change decided above.
    if (running) begin
      if (p1_zero || p2_zero) begin
        nxt     = ST_OVER;
        nxt_win = {p2_zero, p1_zero};
      end else if (p1_die && p2_die) begin
        nxt     = ST_OVER;
        nxt_win = WIN_NONE;
      end else if (time_left == 8'd0) begin
        nxt     = ST_OVER;
        nxt_win = timeout_winner(p1_pos, p2_pos, p1_die, p2_die);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      round_rst <= 1'b0;
      en        <= 1'b0;
      allow     <= 1'b0;
      countdown <= 2'd0;
      time_left <= 8'(GAME_SEC);
      winner    <= WIN_NONE;
      ph_cnt    <= '0;
      green_len <= '0;
      sec_sub   <= 8'd0;
      lfsr      <= 8'hA5;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      state     <= nxt;
      winner    <= nxt_win;
      round_rst <= (nxt == ST_READY) && (state != ST_READY);
      en        <= (nxt == ST_GREEN) || (nxt == ST_RED);
      allow     <= (nxt == ST_GREEN);

      if (tick_clr) begin
        ph_cnt <= '0;
      end else if (tick) begin
        ph_cnt <= ph_cnt + PW'(1);
      end

      if (nxt == ST_GREEN && state != ST_GREEN) begin
        green_len <= PW'(GREEN_MIN) + PW'(lfsr[3:0]);
      end

      if (nxt != ST_READY) begin
        countdown <= 2'd0;
      end else if (state != ST_READY) begin
        countdown <= 2'd3;
      end else if (sec_last) begin
        countdown <= countdown - 2'd1;
      end

      if (state == ST_READY && nxt == ST_GREEN) begin
        time_left <= 8'(GAME_SEC);
      end else if (running && sec_last && time_left != 8'd0) begin
        time_left <= time_left - 8'd1;
      end

      // The seconds sub-counter serves both the READY digits and the game clock.
      if ((nxt == ST_READY && state != ST_READY) || (state == ST_READY && nxt == ST_GREEN)) begin
        sec_sub <= 8'd0;
      end else if (tick && (running || state == ST_READY)) begin
        sec_sub <= sec_last ? 8'd0 : sec_sub + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: phase timing, end checks, winners, start filtering, async reset.
module tb_round_sequencer;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] p1_pos;
  logic [4:0] p2_pos;
  logic       p1_die;
  logic       p2_die;

  logic       round_rst, en, allow;
  logic [2:0] phase;
  logic [1:0] countdown, winner;
  logic [7:0] time_left;

  logic       l_round_rst, l_en, l_allow;
  logic [2:0] l_phase;
  logic [1:0] l_countdown, l_winner;
  logic [7:0] l_time_left;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] m_lfsr;
  logic [7:0] la;
  logic       found;

  always #5 clk = ~clk;

  round_sequencer #(
    .TICK_DIV(4), .SEC_TICKS(2), .GREEN_MIN(4), .TURN_TICKS(2), .RED_TICKS(6), .GAME_SEC(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .p1_pos(p1_pos), .p2_pos(p2_pos),
    .p1_die(p1_die), .p2_die(p2_die), .round_rst(round_rst), .en(en), .allow(allow),
    .phase(phase), .countdown(countdown), .time_left(time_left), .winner(winner)
  );

  // Same timing, longer game clock, so a full green/turn/red cycle can be observed.
  round_sequencer #(
    .TICK_DIV(4), .SEC_TICKS(2), .GREEN_MIN(4), .TURN_TICKS(2), .RED_TICKS(6), .GAME_SEC(20)
  ) dut_long (
    .clk(clk), .rst(rst), .start(start), .p1_pos(p1_pos), .p2_pos(p2_pos),
    .p1_die(p1_die), .p2_die(p2_die), .round_rst(l_round_rst), .en(l_en), .allow(l_allow),
    .phase(l_phase), .countdown(l_countdown), .time_left(l_time_left), .winner(l_winner)
  );

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= lfsr_adv(m_lfsr, 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    p1_pos = POS_START;
    p2_pos = POS_START;
    p1_die = 1'b0;
    p2_die = 1'b0;

    // Reset values
    cyc(3);
    check("rst_phase", phase, 0);
    check("rst_en", en, 0);
    check("rst_allow", allow, 0);
    check("rst_countdown", countdown, 0);
    check("rst_time_left", time_left, 5);
    check("rst_winner", winner, 0);
    check("rst_round_rst", round_rst, 0);
    rst = 1'b1;
    cyc(2);

    // Choose the start cycle so the low LFSR nibble sampled at GREEN entry is 3
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      la = lfsr_adv(m_lfsr, 24);
      if (la[3:0] == 4'd3) found = 1'b1;
      else cyc(1);
    end
    check("lfsr_search", found, 1);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("ready_phase", phase, 1);
    check("ready_round_rst", round_rst, 1);
    check("ready_cd3", countdown, 3);
    check("ready_en", en, 0);
    cyc(1);
    check("round_rst_one_cycle", round_rst, 0);
    cyc(6);
    check("cd3_last", countdown, 3);
    cyc(1);
    check("cd2", countdown, 2);
    cyc(8);
    check("cd1", countdown, 1);
    cyc(7);
    check("ready_last", phase, 1);
    cyc(1);
    check("green_phase", phase, 2);
    check("green_en", en, 1);
    check("green_allow", allow, 1);
    check("green_cd0", countdown, 0);
    check("green_time_left", time_left, 5);
    check("long_green", l_phase, 2);

    // GREEN 28, TURN 8, RED 24 cycles
    cyc(27);
    check("green_last", l_phase, 2);
    cyc(1);
    check("turn_phase", l_phase, 3);
    check("turn_en", l_en, 0);
    check("turn_allow", l_allow, 0);
    check("turn_en_short", en, 0);
    cyc(7);
    check("turn_last", l_phase, 3);
    cyc(1);
    check("red_phase", l_phase, 4);
    check("red_en", l_en, 1);
    check("red_allow", l_allow, 0);
    check("red_phase_short", phase, 4);
    check("red_time_left", time_left, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("red_start_ignored", phase, 4);
    check("red_start_no_rr", round_rst, 0);
    cyc(3);
    check("timeout_tl0", time_left, 0);
    check("timeout_not_yet", phase, 4);
    cyc(1);
    check("timeout_tie_over", phase, 5);
    check("timeout_tie_win", winner, 3);
    check("timeout_tie_en", en, 0);
    cyc(18);
    check("red_last", l_phase, 4);
    cyc(1);
    check("green_again", l_phase, 2);
    check("green_again_allow", l_allow, 1);

    // Restart from OVER, then P2 reaches the line
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("over_restart_phase", phase, 1);
    check("over_restart_win", winner, 0);
    check("over_restart_rr", round_rst, 1);
    cyc(24);
    check("r2_green", phase, 2);
    check("r2_time_reload", time_left, 5);
    cyc(3);
    p2_pos = 5'd0;
    cyc(1);
    check("p2_line_over", phase, 5);
    check("p2_line_win", winner, 2);
    check("p2_line_en", en, 0);
    check("p2_line_allow", allow, 0);
    p2_pos = POS_START;

    // Both reach the line in the same cycle
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(24);
    check("r3_green", phase, 2);
    cyc(2);
    p1_pos = 5'd0;
    p2_pos = 5'd0;
    cyc(1);
    check("both_line_over", phase, 5);
    check("both_line_win", winner, 3);
    p1_pos = POS_START;
    p2_pos = POS_START;

    // One death continues, second death ends with no winner
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(24);
    p1_die = 1'b1;
    cyc(4);
    check("one_dead_phase", phase, 2);
    check("one_dead_en", en, 1);
    p2_die = 1'b1;
    cyc(1);
    check("both_dead_over", phase, 5);
    check("both_dead_win", winner, 0);
    p1_die = 1'b0;
    p2_die = 1'b0;

    // Time-out with p1=12, p2=9
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(24);
    check("r5_green", phase, 2);
    check("r5_time5", time_left, 5);
    p1_pos = 5'd12;
    p2_pos = 5'd9;
    cyc(8);
    check("r5_time4", time_left, 4);
    cyc(31);
    check("r5_time1", time_left, 1);
    cyc(1);
    check("r5_time0", time_left, 0);
    check("r5_not_over_yet", (phase == 3'd5), 0);
    cyc(1);
    check("r5_over", phase, 5);
    check("r5_win_p2", winner, 2);

    // Same, but P2 dead: P1 is the only live player
    p2_die = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("r6_ready", phase, 1);
    cyc(24);
    check("r6_green", phase, 2);
    cyc(41);
    check("r6_over", phase, 5);
    check("r6_win_p1", winner, 1);
    p2_die = 1'b0;
    p1_pos = POS_START;
    p2_pos = POS_START;

    // Asynchronous reset mid-GREEN
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(24);
    cyc(10);
    check("r7_en", en, 1);
    check("r7_time4", time_left, 4);
    #2;
    rst = 1'b0;
    #1;
    check("arst_phase", phase, 0);
    check("arst_en", en, 0);
    check("arst_allow", allow, 0);
    check("arst_time_left", time_left, 5);
    check("arst_countdown", countdown, 0);
    check("arst_winner", winner, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2);
    check("post_rst_idle", phase, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
